// File: rtl/protocol_pkg.sv
// Shared definitions for the single-wire request protocol (initiator and responder).
package protocol_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    ACK    = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } resp_state_t;

  localparam int RESP_DELAY_DEF = 2;
  localparam int TIMEOUT_DEF    = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/protocol_cycle_timer.sv
// Loadable up-counter with synchronous clear and a terminal-match flag.
module protocol_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         match
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // Match is combinational so the FSM can leave a state on the terminal edge.
  assign match = (cnt == term);

endmodule

// File: rtl/protocol_resp_fsm.sv
// Responder side of the 4-phase req/ack protocol: capture, delayed ack, completion and error reporting.
// Handshake: req is a level; ack rises RESP_DELAY edges after req is first sampled and falls once req is sampled low.
module protocol_resp_fsm
  import protocol_pkg::*;
#(
  parameter int RESP_DELAY = RESP_DELAY_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  input  logic              clr_err,
  output logic              ack,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  txn_count,
  output logic [2:0]        dbg_state
);

  localparam int TW = $clog2(max_int(RESP_DELAY, TIMEOUT) + 1);
  localparam logic [TW-1:0] ACC_TERM = (RESP_DELAY > 0) ? TW'(RESP_DELAY - 1) : '0;
  localparam logic [TW-1:0] ACK_TERM = TW'(TIMEOUT - 1);

  resp_state_t   state, state_nx;
  logic          tmr_clr, tmr_en, tmr_match;
  logic          err_set, capture;
  logic [TW-1:0] tmr_term;

  assign tmr_term = (state == ACCEPT) ? ACC_TERM : ACK_TERM;

  protocol_cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (tmr_en),
    .term     (tmr_term),
    .match    (tmr_match)
  );

  always_comb begin
    state_nx = state;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    err_set  = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture  = 1'b1;
          tmr_clr  = 1'b1;
          state_nx = (RESP_DELAY == 0) ? ACK : ACCEPT;
        end
      end
      ACCEPT: begin
        if (!req) begin
          state_nx = IDLE;
          err_set  = 1'b1;
        end else if (tmr_match) begin
          state_nx = ACK;
          tmr_clr  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ACK: begin
        // A release on the timeout edge still completes normally.
        if (!req) begin
          state_nx = DONE;
        end else if (tmr_match) begin
          state_nx = ERROR;
          err_set  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      ERROR:   if (!req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err       <= 1'b0;
      txn_count <= '0;
    end else begin
      state     <= state_nx;
      ack       <= (state_nx == ACK);
      rsp_valid <= (state_nx == DONE);
      if (capture) rsp_data <= req_data;
      if (state_nx == DONE) txn_count <= txn_count + CNT_W'(1);
      if (err_set) err <= 1'b1;
      else if (clr_err) err <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_protocol_resp_fsm.sv
// Randomized scoreboard bench: two responders (RESP_DELAY=2 and RESP_DELAY=0) driven by identical req traffic.
module tb_protocol_resp_fsm;

  localparam int T  = 16;
  localparam int NDUT = 2;

  logic       clk, rst, req, clr_err;
  logic [7:0] req_data;
  logic       ack       [NDUT];
  logic       rsp_valid [NDUT];
  logic [7:0] rsp_data  [NDUT];
  logic       busy      [NDUT];
  logic       err       [NDUT];
  logic [7:0] txn_count [NDUT];
  logic [2:0] dbg_state [NDUT];

  int n_cmp = 0;
  int n_fail = 0;

  // Expected outcomes per responder.
  logic [15:0] exp_q  [NDUT][$];
  logic [7:0]  ackw_q [NDUT][$];
  logic [7:0]  exp_count [NDUT];
  logic        exp_err   [NDUT];
  logic [7:0]  last_data [NDUT];
  int          run       [NDUT];

  protocol_resp_fsm #(.RESP_DELAY(2), .TIMEOUT(T), .DATA_W(8), .CNT_W(8)) dut_d2 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .clr_err(clr_err),
    .ack(ack[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .busy(busy[0]),
    .err(err[0]), .txn_count(txn_count[0]), .dbg_state(dbg_state[0])
  );

  protocol_resp_fsm #(.RESP_DELAY(0), .TIMEOUT(T), .DATA_W(8), .CNT_W(8)) dut_d0 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .clr_err(clr_err),
    .ack(ack[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .busy(busy[1]),
    .err(err[1]), .txn_count(txn_count[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dly(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < NDUT; i++) begin
      exp_q[i].delete();
      ackw_q[i].delete();
      exp_count[i] = '0;
      exp_err[i]   = 1'b0;
      last_data[i] = '0;
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s ack[%0d]", tag, i), 32'(ack[i]), 0);
      check($sformatf("%s rsp_valid[%0d]", tag, i), 32'(rsp_valid[i]), 0);
      check($sformatf("%s busy[%0d]", tag, i), 32'(busy[i]), 0);
      check($sformatf("%s err[%0d]", tag, i), 32'(err[i]), 0);
      check($sformatf("%s txn_count[%0d]", tag, i), 32'(txn_count[i]), 0);
      check($sformatf("%s rsp_data[%0d]", tag, i), 32'(rsp_data[i]), 0);
    end
  endtask

  // Reference model: the outcome of a transaction follows from how many edges req is held
  // relative to the ack delay D and the timeout window T.
  task automatic predict(input logic [7:0] data, input int hold, input bit clr);
    for (int i = 0; i < NDUT; i++) begin
      int d = dly(i);
      last_data[i] = data;
      if (d > 0 && hold <= d) begin
        exp_err[i] = 1'b1;
      end else begin
        int ack_end = (hold < d + T) ? hold : d + T;
        ackw_q[i].push_back(8'(ack_end - d));
        if (hold <= d + T) begin
          exp_count[i] = exp_count[i] + 8'd1;
          exp_q[i].push_back({exp_count[i], data});
          if (clr) exp_err[i] = 1'b0;
        end else begin
          exp_err[i] = !clr;
        end
      end
    end
  endtask

  // Called just after a falling edge; req is sampled high for `hold` edges, then low for two.
  task automatic txn(input logic [7:0] data, input int hold, input bit clr);
    predict(data, hold, clr);
    req = 1'b1;
    req_data = data;
    repeat (hold) @(negedge clk);
    req = 1'b0;
    req_data = 8'($urandom);
    clr_err = clr;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("post busy[%0d]", i), 32'(busy[i]), 0);
      check($sformatf("post err[%0d]", i), 32'(err[i]), 32'(exp_err[i]));
      check($sformatf("post rsp_data[%0d]", i), 32'(rsp_data[i]), 32'(last_data[i]));
      check($sformatf("post txn_count[%0d]", i), 32'(txn_count[i]), 32'(exp_count[i]));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        run[i] = 0;
      end else begin
        if (ack[i]) begin
          run[i]++;
        end else if (run[i] != 0) begin
          if (ackw_q[i].size() == 0) check($sformatf("unexpected ack[%0d]", i), 32'(run[i]), 0);
          else check($sformatf("ack width[%0d]", i), 32'(run[i]), 32'(ackw_q[i].pop_front()));
          run[i] = 0;
        end
        if (rsp_valid[i]) begin
          check($sformatf("ack low at rsp_valid[%0d]", i), 32'(ack[i]), 0);
          if (exp_q[i].size() == 0) check($sformatf("unexpected rsp_valid[%0d]", i), 1, 0);
          else check($sformatf("rsp count,data[%0d]", i), 32'({txn_count[i], rsp_data[i]}),
                     32'(exp_q[i].pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit waited;
    for (int i = 0; i < NDUT; i++) run[i] = 0;
    flush_model();
    rst = 1'b0; req = 1'b0; clr_err = 1'b0; req_data = 8'h00;
    #1 rst = 1'b1;
    #1 check_quiet("reset async");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_quiet("reset held");

    // Nominal transaction.
    txn(8'hA5, 5, 1'b0);
    // Release after one edge: abort for the delayed responder.
    txn(8'h11, 1, 1'b0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    for (int i = 0; i < NDUT; i++) exp_err[i] = 1'b0;
    for (int i = 0; i < NDUT; i++) check($sformatf("clr_err err[%0d]", i), 32'(err[i]), 0);
    // Timeout, then release exactly on the timeout edge.
    txn(8'h5E, 30, 1'b0);
    txn(8'h77, 18, 1'b0);
    // Abort while clr_err is asserted on the same edge: set wins.
    txn(8'h22, 2, 1'b1);

    // Back-to-back traffic long enough to wrap the counter.
    for (int n = 0; n < 260; n++) txn(8'($urandom), $urandom_range(1, 3), 1'b0);

    // Mixed random traffic around the delay and timeout boundaries.
    for (int n = 0; n < 200; n++) begin
      int hold;
      case ($urandom_range(0, 3))
        0:       hold = $urandom_range(1, 3);
        1:       hold = $urandom_range(15, 19);
        2:       hold = $urandom_range(1, 25);
        default: hold = $urandom_range(2, 6);
      endcase
      txn(8'($urandom), hold, ($urandom_range(0, 3) == 0));
    end

    // Reset while ack is high.
    req = 1'b1;
    req_data = 8'h3C;
    waited = 1'b0;
    for (int k = 0; k < 10 && !waited; k++) begin
      @(negedge clk);
      if (ack[0]) waited = 1'b1;
    end
    check("wait for ack before reset", 32'(waited), 1);
    #2 rst = 1'b1;
    flush_model();
    #1 check_quiet("reset mid-ack");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn(8'h3C, 5, 1'b0);

    repeat (4) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("leftover rsp[%0d]", i), 32'(exp_q[i].size()), 0);
      check($sformatf("leftover ack[%0d]", i), 32'(ackw_q[i].size()), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/protocol_resp_fsm.md
Name: protocol_resp_fsm

Overview:
Responder end of the single-wire request protocol driven by protocol_fsm.
- Samples the initiator's request level and captures its data word.
- Raises an acknowledge after a programmable latency and holds it until the request drops (4-phase handshake).
- Reports completed transactions and sticky protocol errors (abort, timeout) to the local side.

Parameters:
RESP_DELAY, 2, cycles from the request-sampled edge to ack assertion (0 allowed)
TIMEOUT, 16, maximum cycles ack may stay high while req is still asserted (>=1)
DATA_W, 8, width of request/response data
CNT_W, 8, width of the completed-transaction counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  1  request level from initiator
req_data  input  DATA_W  initiator data, valid when req first sampled high
clr_err  input  1  synchronous clear of sticky err
ack  output  1  acknowledge to initiator, registered
rsp_valid  output  1  one-cycle pulse: transaction completed
rsp_data  output  DATA_W  captured req_data, stable from rsp_valid until next capture
busy  output  1  state != IDLE
err  output  1  sticky error flag
txn_count  output  CNT_W  completed transactions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, takes effect without a clock edge):
  - state IDLE, all counters 0.
  - ack, rsp_valid, rsp_data, busy, err, txn_count all 0.
- Single clock domain; req is used as sampled, with no synchronizer.
- Edge numbering: E0 is the edge at which IDLE samples req=1.
- IDLE: on req=1, capture req_data and clear the cycle counter.
  - RESP_DELAY=0: go to ACK.
  - Otherwise: go to ACCEPT.
- ACCEPT: counter increments each edge; goes to ACK at edge E0+RESP_DELAY.
  - req sampled 0 in ACCEPT (abort): go to IDLE, set err, no ack, no rsp_valid, txn_count unchanged.
- ACK: ack=1 (ack is 1 exactly while state==ACK).
  - Counter restarts at entry; ack first high after edge E0+RESP_DELAY.
  - req sampled 0: go to DONE.
  - Otherwise, at the TIMEOUT-th edge after entry: go to ERROR.
  - req=0 on that same edge: DONE wins.
- DONE: exactly one cycle.
  - ack=0, rsp_valid=1, txn_count+1 (wraps).
  - Always returns to IDLE; req is ignored in DONE.
- ERROR: ack=0, err set; stays until req sampled 0, then IDLE; no rsp_valid.
- err: set on abort or timeout; cleared only by rst or clr_err.
  - Set and clr_err on the same edge: set wins.
- busy is decoded from the state register; high in ACCEPT, ACK, DONE and ERROR.
- rsp_data updates only on capture in IDLE.
- Back-to-back transactions: req may rise in the cycle after DONE; minimum gap between ack pulses is 2 cycles.
- Reset mid-transaction: ack drops immediately, no rsp_valid pulse, counter and err cleared.

Decomposition:
- protocol_pkg (shared with protocol_fsm):
  - resp_state_t enum: IDLE, ACCEPT, ACK, DONE, ERROR.
  - Default constants RESP_DELAY_DEF=2, TIMEOUT_DEF=16.
- One natural sub-module: protocol_cycle_timer.
  - Loadable up-counter with clear and terminal-match output.
  - Shared by the ACCEPT delay and the ACK timeout; width $clog2(max(RESP_DELAY, TIMEOUT)+1).
- FSM and output registers stay in protocol_resp_fsm.

Test Plan:
1. Reset: rst=1 for 2 cycles, then also pulsed asynchronously between edges -> ack/rsp_valid/busy/err=0, txn_count=0, rsp_data=0, with no edge required.
2. Nominal, defaults: req=1 and req_data=0xA5 sampled at E0, req dropped before E5 -> ack=1 after E2 through E4; ack=0 and rsp_valid=1 for one cycle after E5; rsp_data=0xA5; txn_count=1.
3. Abort: req high at E0, low at E1 -> ack never rises, err=1 after E1, txn_count unchanged; clr_err pulse -> err=0.
4. Timeout: req held high 30 cycles -> ack high after E2, ERROR at E18, ack=0, err=1, no rsp_valid; req dropped -> IDLE, busy=0. Variant with req=0 exactly at E18 -> DONE, rsp_valid=1, err=0.
5. Back-to-back and wrap: 256 transactions with 1-cycle gaps, RESP_DELAY=0 -> ack after E0 each time, txn_count returns to 0x00, rsp_data tracks each req_data.
6. Reset mid-ACK: rst asserted while ack=1 -> ack=0 immediately; after release with req still high -> new transaction, ack after E0+2.
